// File: rtl/demux_deser_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_deser_pkg
//  Description : Shared types and helpers for the two-channel deserializer.
//  Revision    : 1.0  initial release
// ============================================================================
package demux_deser_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Holding-register occupancy per channel
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hold_st_t;

  // Bit-counter width able to count 0..width-1 (never narrower than 1 bit)
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/deser_chan.sv
`default_nettype none
// ============================================================================
//  Module      : deser_chan
//  Description : One deserializer channel: MSB-first shift register, bit
//                counter, one-word holding register with valid/ready and a
//                sticky overflow flag.
//  Revision    : 1.0  initial release
// ============================================================================
module deser_chan
  import demux_deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             y,
  output logic [WIDTH-1:0] data,
  output logic             vld,
  input  logic             rdy,
  output logic             ovf
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             ovf_q,   ovf_d;
  hold_st_t         hold_st_q, hold_st_d;

  logic             w_done;
  logic [WIDTH-1:0] w_word;

  // The completing bit is part of the word, so the word is built from the
  // shift contents plus the bit arriving on this edge.
  assign w_done = bit_en && (cnt_q == CW'(WIDTH - 1));
  assign w_word = {shift_q[WIDTH-2:0], y};

  // Next-state: partial-word accumulation plus holding-register FSM
  always_comb begin
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    ovf_d     = ovf_q;
    hold_st_d = hold_st_q;

    // Accumulation runs regardless of the holding-register state
    if (bit_en) begin
      shift_d = w_word;
      cnt_d   = w_done ? '0 : cnt_q + CW'(1);
    end

    case (hold_st_q)
      EMPTY: begin
        if (w_done) begin
          data_d    = w_word;
          hold_st_d = FULL;
        end
      end
      FULL: begin
        if (w_done) begin
          // A same-edge transfer frees the slot, so the new word loads with no bubble
          if (rdy) begin
            data_d = w_word;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (rdy) begin
          hold_st_d = EMPTY;
        end
      end
      default: hold_st_d = EMPTY;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      ovf_q     <= 1'b0;
      hold_st_q <= EMPTY;
    end else begin
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      ovf_q     <= ovf_d;
      hold_st_q <= hold_st_d;
    end
  end

  assign data = data_q;
  assign vld  = (hold_st_q == FULL);
  assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: rtl/demux_deser_2ch.sv
`default_nettype none
// ============================================================================
//  Module      : demux_deser_2ch
//  Description : Two-channel serial-to-parallel capture stage. Each strobed
//                bit is steered by the select into one deserializer channel.
//  Revision    : 1.0  initial release
// ============================================================================
module demux_deser_2ch
  import demux_deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             y,
  input  logic             s,
  input  logic             bit_vld,
  output logic [WIDTH-1:0] ch0_data,
  output logic             ch0_vld,
  input  logic             ch0_rdy,
  output logic             ch0_ovf,
  output logic [WIDTH-1:0] ch1_data,
  output logic             ch1_vld,
  input  logic             ch1_rdy,
  output logic             ch1_ovf
);

  logic w_bit_en0;
  logic w_bit_en1;

  // Only the selected channel sees the strobe; the other is left untouched
  assign w_bit_en0 = bit_vld & ~s;
  assign w_bit_en1 = bit_vld &  s;

  deser_chan #(.WIDTH(WIDTH)) u_chan0 (
    .clk    (clk),
    .rst    (rst),
    .bit_en (w_bit_en0),
    .y      (y),
    .data   (ch0_data),
    .vld    (ch0_vld),
    .rdy    (ch0_rdy),
    .ovf    (ch0_ovf)
  );

  deser_chan #(.WIDTH(WIDTH)) u_chan1 (
    .clk    (clk),
    .rst    (rst),
    .bit_en (w_bit_en1),
    .y      (y),
    .data   (ch1_data),
    .vld    (ch1_vld),
    .rdy    (ch1_rdy),
    .ovf    (ch1_ovf)
  );

endmodule
`default_nettype wire

// File: tb/tb_demux_deser_2ch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_deser_2ch
//  Description : Directed self-checking bench for demux_deser_2ch (WIDTH=8).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_demux_deser_2ch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       y = 1'b0;
  logic       s = 1'b0;
  logic       bit_vld = 1'b0;
  logic [7:0] ch0_data;
  logic       ch0_vld;
  logic       ch0_rdy = 1'b0;
  logic       ch0_ovf;
  logic [7:0] ch1_data;
  logic       ch1_vld;
  logic       ch1_rdy = 1'b0;
  logic       ch1_ovf;

  int checks = 0;
  int errors = 0;

  demux_deser_2ch #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .y        (y),
    .s        (s),
    .bit_vld  (bit_vld),
    .ch0_data (ch0_data),
    .ch0_vld  (ch0_vld),
    .ch0_rdy  (ch0_rdy),
    .ch0_ovf  (ch0_ovf),
    .ch1_data (ch1_data),
    .ch1_vld  (ch1_vld),
    .ch1_rdy  (ch1_rdy),
    .ch1_ovf  (ch1_ovf)
  );

  always #5 clk = ~clk;

  // Word-level vector: send one word, check right after its last bit,
  // then check valid flags once more after one idle cycle.
  typedef struct {
    logic       ch;
    logic [7:0] word;
    logic       r0, r1;
    logic [7:0] d0; logic v0, o0;
    logic [7:0] d1; logic v1, o1;
    logic       nv0, nv1;
  } vec_t;

  vec_t vecs[5];

  // Advance one edge; inputs are changed and outputs sampled 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name,
                           input logic [7:0] d0, input logic v0, input logic o0,
                           input logic [7:0] d1, input logic v1, input logic o1);
    check(name, {10'd0, ch0_data, ch0_vld, ch0_ovf, ch1_data, ch1_vld, ch1_ovf},
                {10'd0, d0, v0, o0, d1, v1, o1});
  endtask

  task automatic send_bit(input logic c, input logic b);
    bit_vld = 1'b1;
    s       = c;
    y       = b;
    tick();
    bit_vld = 1'b0;
  endtask

  // Send the top n bits of w, MSB first, back to back
  task automatic send_word(input logic c, input logic [7:0] w, input int n);
    for (int i = 7; i >= 8 - n; i--) send_bit(c, w[i]);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bit_vld = 1'b0;
    tick();
    tick();
    rst     = 1'b0;
  endtask

  initial begin
    logic [7:0] w0;
    logic [7:0] w1;

    // ch, word, r0, r1, d0, v0, o0, d1, v1, o1, nv0, nv1
    vecs[0] = '{1'b0, 8'hA6, 1'b1, 1'b1, 8'hA6, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h3C, 1'b1, 1'b1, 8'hA6, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'h11, 1'b1, 1'b0, 8'hA6, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'h22, 1'b1, 1'b0, 8'hA6, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 8'h5C, 1'b1, 1'b0, 8'h5C, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset, then idle with everything at zero
    do_reset();
    check_all("reset", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_all($sformatf("idle%0d", i), 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    end

    // Table: single words, then backpressure and overflow on channel 1
    for (int i = 0; i < 5; i++) begin
      ch0_rdy = vecs[i].r0;
      ch1_rdy = vecs[i].r1;
      send_word(vecs[i].ch, vecs[i].word, 8);
      check_all($sformatf("vec%0d_word", i), vecs[i].d0, vecs[i].v0, vecs[i].o0,
                vecs[i].d1, vecs[i].v1, vecs[i].o1);
      tick();
      check($sformatf("vec%0d_next_vld", i), {30'd0, ch0_vld, ch1_vld},
            {30'd0, vecs[i].nv0, vecs[i].nv1});
    end

    // Raising ready drains the held 0x11; overflow stays sticky
    check("bp_held_data", ch1_data, 8'h11);
    ch1_rdy = 1'b1;
    tick();
    check("bp_drain", {23'd0, ch1_data, ch1_vld, ch1_ovf}, {23'd0, 8'h11, 1'b0, 1'b1});

    // Interleave: ch0 gets 0xF0, ch1 gets 0x0F, alternating select
    do_reset();
    ch0_rdy = 1'b1;
    ch1_rdy = 1'b1;
    w0 = 8'hF0;
    w1 = 8'h0F;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b0, w0[i]);
      if (i == 0) check_all("ilv_ch0", 8'hF0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      send_bit(1'b1, w1[i]);
    end
    check_all("ilv_ch1", 8'hF0, 1'b0, 1'b0, 8'h0F, 1'b1, 1'b0);

    // Same-edge transfer and load on channel 0
    do_reset();
    ch0_rdy = 1'b0;
    send_word(1'b0, 8'h33, 8);
    send_word(1'b0, 8'h44, 7);
    check("same_hold", {23'd0, ch0_data, ch0_vld, ch0_ovf}, {23'd0, 8'h33, 1'b1, 1'b0});
    ch0_rdy = 1'b1;
    w0 = 8'h44;
    send_bit(1'b0, w0[0]);
    check("same_load", {23'd0, ch0_data, ch0_vld, ch0_ovf}, {23'd0, 8'h44, 1'b1, 1'b0});
    tick();
    check("same_drain", {31'd0, ch0_vld}, 32'd0);

    // Reset mid-word, with a strobe on the reset edge that must be ignored
    do_reset();
    send_word(1'b0, 8'hFF, 5);
    rst     = 1'b1;
    bit_vld = 1'b1;
    s       = 1'b0;
    y       = 1'b1;
    tick();
    rst     = 1'b0;
    bit_vld = 1'b0;
    check_all("midrst", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    send_word(1'b0, 8'h5A, 7);
    check("midrst_7bits", {31'd0, ch0_vld}, 32'd0);
    w0 = 8'h5A;
    send_bit(1'b0, w0[0]);
    check("midrst_word", {23'd0, ch0_data, ch0_vld, ch0_ovf}, {23'd0, 8'h5A, 1'b1, 1'b0});

    // Gaps between strobes freeze accumulation
    w1 = 8'hC3;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, w1[i]);
      if (i != 0) begin
        tick();
        tick();
        tick();
      end
    end
    check("gap_word", {23'd0, ch1_data, ch1_vld, ch1_ovf}, {23'd0, 8'hC3, 1'b1, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
